conv_tile_mac_engine: RTL

//  Parametrised successor of the float16 para-scale conv unit: PARA_X*PARA_Y lanes of signed

---
 rtl/conv_tile_mac_engine.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/conv_tile_mac_engine.sv
// Purpose: PARA_X*PARA_Y-lane signed fixed-point MAC; K*K*C taps per output tile, with round, saturate and optional ReLU.
// Latency: a tile appears on out_valid 2 edges after its last tap is accepted (sooner is impossible; later if the output slot is full).
// Backpressure: in_ready drops for one FLUSH cycle per tile, and stays low in HOLD while the single output slot is occupied.
module conv_tile_mac_engine #(
  parameter int PARA_X = 4,
  parameter int PARA_Y = 4,
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int ACC_W  = 40,
  parameter int KMAX   = 7,
  parameter int CH_W   = 8,
  parameter int TILE_W = 12
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [3:0]                        cfg_kernel,
  input  logic [CH_W-1:0]                   cfg_channels,
  input  logic [TILE_W-1:0]                 cfg_tiles,
  input  logic                              cfg_relu,
  output logic                              busy,
  output logic                              cfg_err,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [PARA_X*PARA_Y*DATA_W-1:0]   in_data,
  input  logic [DATA_W-1:0]                 in_weight,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [PARA_X*PARA_Y*DATA_W-1:0]   out_data,
  output logic                              out_last
);
  localparam int LANES  = PARA_X * PARA_Y;
  localparam int PROD_W = 2 * DATA_W;
  localparam int TAP_W  = 8 + CH_W;   // holds K*K*C for K <= 15
  localparam logic [3:0] KMAX_V = 4'(KMAX);
  localparam logic signed [ACC_W:0] ROUND   = (ACC_W+1)'(64'sd1 <<< (FRAC_W-1));
  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((64'sd1 <<< (DATA_W-1)) - 64'sd1);
  localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, HOLD} state_t;

  typedef struct packed {
    logic [TAP_W-1:0]  taps;
    logic [TILE_W-1:0] tiles;
    logic              relu;
  } job_cfg_t;

  state_t state, state_nxt;
  job_cfg_t cfg_q;
  logic [TAP_W-1:0]  tap_cnt;
  logic [TILE_W-1:0] tile_cnt;
  logic [TAP_W-1:0]  n_taps;
  logic cfg_ok, start_ok, tap_acc, tap_last, tile_last, slot_free;
  logic load_now, set_pend, tile_adv, wr_pend, out_load;
  logic s1_vld, s1_first;
  logic signed [PROD_W-1:0] s1_prod [LANES];
  logic signed [ACC_W-1:0]  acc     [LANES];
  logic [LANES*DATA_W-1:0]  post_data;

  assign n_taps    = TAP_W'(cfg_kernel) * TAP_W'(cfg_kernel) * TAP_W'(cfg_channels);
  assign cfg_ok    = (cfg_kernel != 4'd0) && (cfg_kernel <= KMAX_V) &&
                     (cfg_channels != '0) && (cfg_tiles != '0);
  assign start_ok  = (state == IDLE) && start && cfg_ok;
  assign busy      = (state != IDLE);
  assign in_ready  = (state == ACCUM);
  assign tap_acc   = in_valid && in_ready;
  assign tap_last  = (tap_cnt == cfg_q.taps - TAP_W'(1));
  assign tile_last = (tile_cnt == cfg_q.tiles - TILE_W'(1));
  // A pending write already owns the slot for the coming edge.
  assign slot_free = !wr_pend && (!out_valid || out_ready);
  assign out_load  = load_now || wr_pend;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state and write decisions; a free slot seen in FLUSH stays free for the next edge.
  always_comb begin
    state_nxt = state;
    load_now  = 1'b0;
    set_pend  = 1'b0;
    tile_adv  = 1'b0;
    case (state)
      IDLE:  if (start_ok) state_nxt = ACCUM;
      ACCUM: if (tap_acc && tap_last) state_nxt = FLUSH;
      FLUSH: begin
        // Last tile goes through HOLD so busy drops with the write.
        if (slot_free && !tile_last) begin
          state_nxt = ACCUM;
          set_pend  = 1'b1;
          tile_adv  = 1'b1;
        end else begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (slot_free) begin
          load_now  = 1'b1;
          tile_adv  = 1'b1;
          state_nxt = tile_last ? IDLE : ACCUM;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Job config, tap and tile counters, config error pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_q    <= '0;
      tap_cnt  <= '0;
      tile_cnt <= '0;
      cfg_err  <= 1'b0;
      wr_pend  <= 1'b0;
    end else begin
      cfg_err <= (state == IDLE) && start && !cfg_ok;
      wr_pend <= set_pend;
      if (start_ok) begin
        cfg_q.taps  <= n_taps;
        cfg_q.tiles <= cfg_tiles;
        cfg_q.relu  <= cfg_relu;
        tap_cnt     <= '0;
        tile_cnt    <= '0;
      end else begin
        if (tap_acc)  tap_cnt  <= tap_last ? '0 : tap_cnt + TAP_W'(1);
        if (tile_adv) tile_cnt <= tile_cnt + TILE_W'(1);
      end
    end
  end

  // Stage 1: per-lane products of the accepted tap, tagged with first-of-tile.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_vld   <= 1'b0;
      s1_first <= 1'b0;
      for (int i = 0; i < LANES; i++) s1_prod[i] <= '0;
    end else begin
      s1_vld <= tap_acc;
      if (tap_acc) begin
        s1_first <= (tap_cnt == '0);
        for (int i = 0; i < LANES; i++)
          s1_prod[i] <= PROD_W'($signed(in_data[i*DATA_W +: DATA_W])) * PROD_W'($signed(in_weight));
      end
    end
  end

  // Stage 2: accumulate, restarting on the first tap of each tile; wraps at ACC_W.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LANES; i++) acc[i] <= '0;
    end else if (s1_vld) begin
      for (int i = 0; i < LANES; i++)
        acc[i] <= s1_first ? ACC_W'(s1_prod[i]) : acc[i] + ACC_W'(s1_prod[i]);
    end
  end

  // Post-process: round half up, arithmetic shift, saturate, optional ReLU.
  always_comb begin
    logic signed [ACC_W:0] rnd;
    logic signed [ACC_W:0] r;
    post_data = '0;
    rnd = '0;
    r   = '0;
    for (int i = 0; i < LANES; i++) begin
      rnd = (ACC_W+1)'(acc[i]) + ROUND;
      r   = rnd >>> FRAC_W;
      if (r > SAT_MAX)      r = SAT_MAX;
      else if (r < SAT_MIN) r = SAT_MIN;
      if (cfg_q.relu && r[ACC_W]) r = '0;
      post_data[i*DATA_W +: DATA_W] = r[DATA_W-1:0];
    end
  end

  // Output slot: load (possibly while the old tile is consumed) or drain on out_ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (out_load) begin
      out_valid <= 1'b1;
      out_data  <= post_data;
      out_last  <= load_now && tile_last;  // pending writes are never the last tile
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule
